imm_encoder: RTL and testbench
==============================

// Module: imm_encoder
// PURPOSE
//   Inverse of the immediate sign-extender: packs a 32-bit immediate into the RV32I instruction
//   immediate fields for types I/S/B/U/J, merged onto a base word carrying opcode/rd/rs1/rs2/funct.
//   Flags immediates the chosen type cannot represent exactly.
//   Two-stage valid/ready pipeline; used by the trace/self-test instruction generator feeding imem.
// PARAMETERS
//   DATA_WIDTH  32  instruction/immediate width (only 32 supported)
//   CNT_WIDTH   8   width of saturating error counter
// PORTS
//   clk_i       in   1           clock, rising edge
//   rst_i       in   1           asynchronous reset, active-high
//   valid_i     in   1           request valid
//   ready_o     out  1           block can accept a request this cycle
//   ImmSrc_i    in   3           000 I, 001 B, 010 S, 011 U, 100 J, others invalid
//   Imm_i       in   DATA_WIDTH  immediate value (signed, byte offset for B/J)
//   Base_i      in   DATA_WIDTH  instruction word; its immediate-field bits are ignored
//   valid_o     out  1           result valid
//   ready_i     in   1           downstream accepts result
//   Instr_o     out  DATA_WIDTH  encoded instruction
//   Err_o       out  1           immediate not representable / invalid ImmSrc
//   ErrCnt_o    out  CNT_WIDTH   count of accepted results with Err_o=1, saturating
// BEHAVIOUR
//   Reset (async, rst_i=1): both stage valids 0, valid_o=0, Instr_o=0, Err_o=0, ErrCnt_o=0.
//   Handshake: transfer in when valid_i&&ready_o; out when valid_o&&ready_i.
//   S1 registers request + computes field encoding and Err; S2 is the output register.
//   Latency: accepted on edge N -> valid_o high after edge N+1 (2 registers, no bubble when unstalled).
//   Advance: s2_load = s1_valid && (!valid_o || ready_i); ready_o = !s1_valid || s2_load.
//   Full throughput 1/cycle with ready_i=1; outputs hold stable while valid_o && !ready_i.
//   No combinational path from valid_i to valid_o; ready_o depends on ready_i combinationally.
//   Encoding (B = Base_i, M = Imm_i), non-listed bits taken from B:
//     I: [31:20]=M[11:0];                    ok iff M[31:11] all equal
//     S: [31:25]=M[11:5], [11:7]=M[4:0];     ok iff M[31:11] all equal
//     B: [31]=M[12],[7]=M[11],[30:25]=M[10:5],[11:8]=M[4:1]; ok iff M[31:12] equal && M[0]==0
//     U: [31:12]=M[31:12];                   ok iff M[11:0]==0
//     J: [31]=M[20],[19:12]=M[19:12],[20]=M[11],[30:21]=M[10:1]; ok iff M[31:20] equal && M[0]==0
//     ImmSrc 101/110/111: Instr=B unchanged, Err=1.
//   On Err the truncated bits are still encoded (deterministic); Err_o qualifies the result.
//   ErrCnt_o increments on each output transfer with Err_o=1; holds at all-ones (no wrap).
//   Reset mid-operation discards in-flight requests; first cycle after release ready_o=1.
// TESTING
//   I, Imm=0xFFFFFFFF, Base=0x00000013 -> Instr_o=0xFFF00013, Err_o=0, 2 cycles later.
//   B, Imm=0xFFFFFFFC, Base=0x00000063 -> Instr_o=0xFE000EE3; U, Imm=0x12345000, Base=0x37 -> 0x12345037.
//   I Imm=0x800 -> Err_o=1, Instr_o=0x80000013, ErrCnt_o=1; J Imm=0x3 -> Err_o=1; ImmSrc=111 -> Err_o=1.
//   Back-to-back 4 requests, ready_i=0 for 3 cycles: ready_o low once both stages full, order kept, none lost/duplicated.
//   256+ errored transfers with CNT_WIDTH=8 -> ErrCnt_o saturates at 0xFF.
//   Assert rst_i with both stages full -> valid_o=0, ErrCnt_o=0 immediately (async); next request clean.

Source files
------------

// File: rtl/imm_encoder.sv
// imm_encoder: packs a 32-bit immediate into the RV32I I/S/B/U/J immediate fields of a base word.
// Two-stage valid/ready pipeline: S1 holds the accepted request, S2 holds the encoded result.
module imm_encoder #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  valid_i,
    output logic                  ready_o,
    input  logic [2:0]            ImmSrc_i,
    input  logic [DATA_WIDTH-1:0] Imm_i,
    input  logic [DATA_WIDTH-1:0] Base_i,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic [DATA_WIDTH-1:0] Instr_o,
    output logic                  Err_o,
    output logic [CNT_WIDTH-1:0]  ErrCnt_o
);

    localparam logic [2:0] SRC_I = 3'b000;
    localparam logic [2:0] SRC_B = 3'b001;
    localparam logic [2:0] SRC_S = 3'b010;
    localparam logic [2:0] SRC_U = 3'b011;
    localparam logic [2:0] SRC_J = 3'b100;

    logic                  s1_valid;
    logic [2:0]            s1_src;
    logic [DATA_WIDTH-1:0] s1_imm;
    logic [DATA_WIDTH-1:0] s1_base;

    logic                  s1_load;
    logic                  s2_load;
    logic                  out_fire;

    logic [DATA_WIDTH-1:0] enc_instr;
    logic                  enc_err;
    logic                  fits_11;
    logic                  fits_12;
    logic                  fits_20;

    assign s2_load  = s1_valid && (!valid_o || ready_i);
    assign ready_o  = !s1_valid || s2_load;
    assign s1_load  = valid_i && ready_o;
    assign out_fire = valid_o && ready_i;

    // Upper bits must be a pure sign extension of the field's top bit.
    assign fits_11 = (&s1_imm[31:11]) || !(|s1_imm[31:11]);
    assign fits_12 = (&s1_imm[31:12]) || !(|s1_imm[31:12]);
    assign fits_20 = (&s1_imm[31:20]) || !(|s1_imm[31:20]);

    always_comb begin
        enc_instr = s1_base;
        enc_err   = 1'b0;
        case (s1_src)
            SRC_I: begin
                enc_instr[31:20] = s1_imm[11:0];
                enc_err          = !fits_11;
            end
            SRC_S: begin
                enc_instr[31:25] = s1_imm[11:5];
                enc_instr[11:7]  = s1_imm[4:0];
                enc_err          = !fits_11;
            end
            SRC_B: begin
                enc_instr[31]    = s1_imm[12];
                enc_instr[30:25] = s1_imm[10:5];
                enc_instr[11:8]  = s1_imm[4:1];
                enc_instr[7]     = s1_imm[11];
                enc_err          = !fits_12 || s1_imm[0];
            end
            SRC_U: begin
                enc_instr[31:12] = s1_imm[31:12];
                enc_err          = |s1_imm[11:0];
            end
            SRC_J: begin
                enc_instr[31]    = s1_imm[20];
                enc_instr[30:21] = s1_imm[10:1];
                enc_instr[20]    = s1_imm[11];
                enc_instr[19:12] = s1_imm[19:12];
                enc_err          = !fits_20 || s1_imm[0];
            end
            default: begin
                enc_instr = s1_base;
                enc_err   = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            s1_valid <= 1'b0;
            s1_src   <= '0;
            s1_imm   <= '0;
            s1_base  <= '0;
        end else begin
            if (ready_o) begin
                s1_valid <= valid_i;
            end
            if (s1_load) begin
                s1_src  <= ImmSrc_i;
                s1_imm  <= Imm_i;
                s1_base <= Base_i;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_o <= 1'b0;
            Instr_o <= '0;
            Err_o   <= 1'b0;
        end else if (s2_load) begin
            valid_o <= 1'b1;
            Instr_o <= enc_instr;
            Err_o   <= enc_err;
        end else if (out_fire) begin
            valid_o <= 1'b0;
        end
    end

    // Saturates at all-ones so a long error burst never reads back as a small count.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ErrCnt_o <= '0;
        end else if (out_fire && Err_o && !(&ErrCnt_o)) begin
            ErrCnt_o <= ErrCnt_o + CNT_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_imm_encoder.sv
// Scoreboard bench for imm_encoder: driver pushes model results on accept, monitor pops on output transfer.
module tb_imm_encoder;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        valid_i;
    logic        ready_o;
    logic [2:0]  ImmSrc_i;
    logic [31:0] Imm_i;
    logic [31:0] Base_i;
    logic        valid_o;
    logic        ready_i;
    logic [31:0] Instr_o;
    logic        Err_o;
    logic [7:0]  ErrCnt_o;

    imm_encoder #(.DATA_WIDTH(32), .CNT_WIDTH(8)) dut (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .valid_i  (valid_i),
        .ready_o  (ready_o),
        .ImmSrc_i (ImmSrc_i),
        .Imm_i    (Imm_i),
        .Base_i   (Base_i),
        .valid_o  (valid_o),
        .ready_i  (ready_i),
        .Instr_o  (Instr_o),
        .Err_o    (Err_o),
        .ErrCnt_o (ErrCnt_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [31:0] instr;
        logic        err;
        int          cyc;
        bit          lat;
    } exp_t;

    exp_t sbq[$];
    int   n_chk  = 0;
    int   n_pass = 0;
    int   cyc    = 0;
    int   exp_cnt = 0;
    bit   mon_en = 1'b0;
    bit   chk_lat = 1'b0;
    bit   rnd_done;

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_chk++;
        if (act === expv) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, expv, $time);
    endtask

    // Reference: range/alignment rules on the signed value, fields placed with masks and shifts.
    function automatic logic [32:0] ref_enc(input logic [2:0] src, input logic [31:0] imm,
                                            input logic [31:0] base);
        int signed   v;
        logic [31:0] w;
        bit          ok;
        v = $signed(imm);
        case (src)
            3'd0: begin
                ok = (v >= -2048) && (v <= 2047);
                w  = (base & 32'h000F_FFFF) | ((imm & 32'hFFF) << 20);
            end
            3'd2: begin
                ok = (v >= -2048) && (v <= 2047);
                w  = (base & 32'h01FF_F07F) | (((imm >> 5) & 32'h7F) << 25) | ((imm & 32'h1F) << 7);
            end
            3'd1: begin
                ok = (v >= -4096) && (v <= 4095) && ((imm & 32'h1) == 0);
                w  = (base & 32'h01FF_F07F) | (((imm >> 12) & 32'h1) << 31)
                   | (((imm >> 5) & 32'h3F) << 25) | (((imm >> 1) & 32'hF) << 8)
                   | (((imm >> 11) & 32'h1) << 7);
            end
            3'd3: begin
                ok = (imm & 32'hFFF) == 0;
                w  = (base & 32'h0000_0FFF) | (imm & 32'hFFFF_F000);
            end
            3'd4: begin
                ok = (v >= -(1 << 20)) && (v <= (1 << 20) - 1) && ((imm & 32'h1) == 0);
                w  = (base & 32'h0000_0FFF) | (((imm >> 20) & 32'h1) << 31)
                   | (((imm >> 1) & 32'h3FF) << 21) | (((imm >> 11) & 32'h1) << 20)
                   | (((imm >> 12) & 32'hFF) << 12);
            end
            default: begin
                ok = 1'b0;
                w  = base;
            end
        endcase
        return {!ok, w};
    endfunction

    // Caller is positioned just after a rising edge; returns just after the accepting edge.
    task automatic send(input logic [2:0] src, input logic [31:0] imm, input logic [31:0] base);
        logic [32:0] r;
        exp_t        e;
        bit          fired;
        int          budget;
        valid_i  = 1'b1;
        ImmSrc_i = src;
        Imm_i    = imm;
        Base_i   = base;
        fired    = 1'b0;
        budget   = 200;
        while (!fired && budget > 0) begin
            @(negedge clk_i);
            if (ready_o) begin
                r       = ref_enc(src, imm, base);
                e.instr = r[31:0];
                e.err   = r[32];
                e.cyc   = cyc;
                e.lat   = chk_lat;
                sbq.push_back(e);
                fired   = 1'b1;
            end
            @(posedge clk_i);
            #1;
            budget--;
        end
        if (!fired) begin
            n_chk++;
            $display("FAIL accept_timeout: got ready_o=0 for 200 cycles, expected acceptance");
        end
        valid_i = 1'b0;
    endtask

    task automatic drain();
        int budget;
        ready_i = 1'b1;
        budget  = 100;
        while (sbq.size() != 0 && budget > 0) begin
            @(posedge clk_i);
            #1;
            budget--;
        end
        repeat (2) @(posedge clk_i);
        #1;
        chk("drain_empty", 32'(sbq.size()), 32'd0);
    endtask

    // Monitor: compares each output transfer and checks hold-stability under backpressure.
    initial begin
        exp_t        e;
        bit          prev_stall;
        logic [31:0] prev_instr;
        logic        prev_err;
        prev_stall = 1'b0;
        prev_instr = '0;
        prev_err   = 1'b0;
        forever begin
            @(negedge clk_i);
            if (!mon_en || rst_i) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    chk("hold_valid", {31'd0, valid_o}, 32'd1);
                    chk("hold_instr", Instr_o, prev_instr);
                    chk("hold_err", {31'd0, Err_o}, {31'd0, prev_err});
                end
                if (valid_o && ready_i) begin
                    if (sbq.size() == 0) begin
                        n_chk++;
                        $display("FAIL unexpected_output: got Instr_o=%h with empty queue, expected none", Instr_o);
                    end else begin
                        e = sbq.pop_front();
                        chk("instr", Instr_o, e.instr);
                        chk("err", {31'd0, Err_o}, {31'd0, e.err});
                        chk("errcnt", {24'd0, ErrCnt_o}, 32'(exp_cnt));
                        if (e.lat) chk("latency", 32'(cyc - e.cyc), 32'd2);
                        if (e.err && exp_cnt < 255) exp_cnt++;
                    end
                end
                prev_stall = valid_o && !ready_i;
                prev_instr = Instr_o;
                prev_err   = Err_o;
            end
        end
    end

    function automatic logic [31:0] rand_imm();
        logic [31:0] v;
        case ($urandom_range(0, 4))
            0: v = $urandom;
            1: v = 32'($signed($urandom_range(0, 10000)) - 5000);
            2: v = $urandom & 32'hFFFF_F000;
            3: v = 32'($signed($urandom_range(0, 32'h0040_0000)) - 32'sh0020_0000);
            default: begin
                case ($urandom_range(0, 7))
                    0: v = 32'h0000_07FF;
                    1: v = 32'hFFFF_F800;
                    2: v = 32'h0000_0FFE;
                    3: v = 32'hFFFF_F000;
                    4: v = 32'h000F_FFFE;
                    5: v = 32'hFFF0_0000;
                    6: v = 32'h0010_0000;
                    default: v = 32'h0000_1000;
                endcase
            end
        endcase
        return v;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got no finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        rst_i    = 1'b1;
        valid_i  = 1'b0;
        ready_i  = 1'b0;
        ImmSrc_i = '0;
        Imm_i    = '0;
        Base_i   = '0;
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b0;
        #1;
        chk("rst_valid_o", {31'd0, valid_o}, 32'd0);
        chk("rst_instr_o", Instr_o, 32'd0);
        chk("rst_err_o", {31'd0, Err_o}, 32'd0);
        chk("rst_errcnt_o", {24'd0, ErrCnt_o}, 32'd0);
        chk("rst_ready_o", {31'd0, ready_o}, 32'd1);

        // Directed vectors, unstalled, with latency checking.
        @(posedge clk_i);
        #1;
        ready_i = 1'b1;
        mon_en  = 1'b1;
        chk_lat = 1'b1;
        send(3'b000, 32'hFFFF_FFFF, 32'h0000_0013);
        send(3'b001, 32'hFFFF_FFFC, 32'h0000_0063);
        send(3'b011, 32'h1234_5000, 32'h0000_0037);
        send(3'b000, 32'h0000_0800, 32'h0000_0013);
        send(3'b100, 32'h0000_0003, 32'h0000_006F);
        send(3'b111, 32'h0000_0010, 32'hDEAD_BEEF);
        send(3'b010, 32'hFFFF_F800, 32'h0000_2023);
        send(3'b100, 32'h000F_FFFE, 32'h0000_00EF);
        drain();
        chk_lat = 1'b0;
        chk("errcnt_after_directed", {24'd0, ErrCnt_o}, 32'd3);

        // Backpressure: four back-to-back requests, downstream stalled for three cycles.
        ready_i = 1'b0;
        fork
            begin
                send(3'b000, 32'h0000_0001, 32'h0000_0013);
                send(3'b010, 32'h0000_0004, 32'h0000_2023);
                send(3'b011, 32'hABCD_E000, 32'h0000_0037);
                send(3'b001, 32'h0000_0010, 32'h0000_0063);
            end
            begin
                @(negedge clk_i);
                @(posedge clk_i);
                @(posedge clk_i);
                @(negedge clk_i);
                chk("stall_ready_low", {31'd0, ready_o}, 32'd0);
                chk("stall_valid_high", {31'd0, valid_o}, 32'd1);
                @(posedge clk_i);
                #1;
                ready_i = 1'b1;
            end
        join
        drain();

        // Randomized traffic with random backpressure.
        rnd_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 300; i++) begin
                    send(3'($urandom_range(0, 7) == 7 ? $urandom_range(5, 7) : $urandom_range(0, 4)),
                         rand_imm(), $urandom);
                end
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge clk_i);
                    #1;
                    ready_i = ($urandom_range(0, 9) < 7);
                end
            end
        join
        drain();

        // Counter saturation: enough invalid-source transfers to pass 255.
        for (int i = 0; i < 270; i++) send(3'b111, $urandom, $urandom);
        drain();
        chk("errcnt_saturated", {24'd0, ErrCnt_o}, 32'h0000_00FF);

        // Asynchronous reset with both stages full.
        ready_i = 1'b0;
        send(3'b000, 32'h0000_0005, 32'h0000_0013);
        send(3'b111, 32'h0000_0006, 32'h0000_0013);
        #2;
        chk("full_ready_low", {31'd0, ready_o}, 32'd0);
        mon_en = 1'b0;
        rst_i  = 1'b1;
        #1;
        chk("async_rst_valid_o", {31'd0, valid_o}, 32'd0);
        chk("async_rst_errcnt_o", {24'd0, ErrCnt_o}, 32'd0);
        chk("async_rst_instr_o", Instr_o, 32'd0);
        sbq.delete();
        exp_cnt = 0;
        @(negedge clk_i);
        rst_i = 1'b0;
        #1;
        chk("post_rst_ready_o", {31'd0, ready_o}, 32'd1);
        chk("post_rst_valid_o", {31'd0, valid_o}, 32'd0);
        @(posedge clk_i);
        #1;
        ready_i = 1'b1;
        mon_en  = 1'b1;
        chk_lat = 1'b1;
        send(3'b100, 32'hFFF0_0000, 32'h0000_006F);
        drain();
        chk("post_rst_errcnt", {24'd0, ErrCnt_o}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
